// File: rtl/pe_fetch_ctrl_pkg.sv
// Shared definitions for the PE fetch sequencer.
// State encoding for the IDLE/RUN/DRAIN controller.
package pe_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    PE_FC_IDLE  = 2'd0,
    PE_FC_RUN   = 2'd1,
    PE_FC_DRAIN = 2'd2
  } pe_fc_state_e;

endpackage

// File: rtl/pe_fetch_loop_ctrl.sv
// Zero-overhead hardware loop for the PE fetch path.
// Holds loop bounds, armed flag and remaining count.
module pe_fetch_loop_ctrl #(
  parameter int PC_W       = 10,
  parameter int LOOP_CNT_W = 8
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iLoad,
  input  logic [PC_W-1:0]       iLoop_Start,
  input  logic [PC_W-1:0]       iLoop_End,
  input  logic [LOOP_CNT_W-1:0] iLoop_Count,
  input  logic [PC_W-1:0]       iPC,
  input  logic                  iStep,
  output logic                  oLoop_Take,
  output logic [PC_W-1:0]       oLoop_Start_PC
);

  logic                  armed;
  logic [PC_W-1:0]       start_pc;
  logic [PC_W-1:0]       end_pc;
  logic [LOOP_CNT_W-1:0] remaining;
  logic                  hit;
  logic                  last;
  logic                  take;
  logic                  leave;

  assign hit   = armed && (iPC == end_pc);
  assign last  = (remaining == LOOP_CNT_W'(1));
  assign take  = iStep && hit && !last &&
                 (remaining != '0);
  assign leave = iStep && hit && last;

  assign oLoop_Take     = take;
  assign oLoop_Start_PC = start_pc;

  // A load wins over the decrement; the
  // decision this cycle already used old regs.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      armed     <= 1'b0;
      start_pc  <= '0;
      end_pc    <= '0;
      remaining <= '0;
    end else if (iLoad) begin
      start_pc  <= iLoop_Start;
      end_pc    <= iLoop_End;
      remaining <= iLoop_Count;
      armed     <= (iLoop_Count != '0);
    end else if (take) begin
      remaining <= remaining - LOOP_CNT_W'(1);
    end else if (leave) begin
      remaining <= '0;
      armed     <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_fetch_ctrl.sv
// PE instruction fetch sequencer: PC, IMEM read port,
// branch squash, stall, halt drain and hardware loop.
import pe_fetch_ctrl_pkg::*;

module pe_fetch_ctrl #(
  parameter int PC_W         = 10,
  parameter int LOOP_CNT_W   = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iStart,
  input  logic [PC_W-1:0]       iStart_PC,
  output logic                  oBusy,
  output logic                  oDone,
  input  logic                  iStall,
  input  logic                  iBranch_Valid,
  input  logic [PC_W-1:0]       iBranch_Target,
  input  logic                  iHalt,
  input  logic                  iLoop_Set,
  input  logic [PC_W-1:0]       iLoop_Start,
  input  logic [PC_W-1:0]       iLoop_End,
  input  logic [LOOP_CNT_W-1:0] iLoop_Count,
  output logic [PC_W-1:0]       oIMEM_Addr,
  output logic                  oIMEM_Read_En,
  output logic                  oFetch_Valid
);

  localparam int DW =
    (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'(DRAIN_CYCLES - 1);

  pe_fc_state_e    state;
  logic [PC_W-1:0] pc;
  logic            rd_en;
  logic            fetch_valid;
  logic            done;
  logic [DW-1:0]   drain_cnt;

  logic            frozen;
  logic            run_go;
  logic            squash;
  logic            step;
  logic            loop_take;
  logic [PC_W-1:0] loop_start_pc;

  assign frozen = iStall && (state != PE_FC_IDLE);
  assign run_go = (state == PE_FC_RUN) && !iStall;
  assign squash = run_go && (iHalt || iBranch_Valid);
  assign step   = run_go && !iHalt && !iBranch_Valid;

  pe_fetch_loop_ctrl #(
    .PC_W       (PC_W),
    .LOOP_CNT_W (LOOP_CNT_W)
  ) u_loop (
    .iClk           (iClk),
    .iReset_n       (iReset_n),
    .iLoad          (iLoop_Set && !frozen),
    .iLoop_Start    (iLoop_Start),
    .iLoop_End      (iLoop_End),
    .iLoop_Count    (iLoop_Count),
    .iPC            (pc),
    .iStep          (step),
    .oLoop_Take     (loop_take),
    .oLoop_Start_PC (loop_start_pc)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= PE_FC_IDLE;
      pc          <= '0;
      rd_en       <= 1'b0;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      // The word returning now was fetched last
      // cycle; a branch/halt makes it wrong-path.
      if (!frozen)
        fetch_valid <= rd_en && !squash;
      case (state)
        PE_FC_IDLE: begin
          if (iStart) begin
            pc    <= iStart_PC;
            rd_en <= 1'b1;
            state <= PE_FC_RUN;
          end
        end
        PE_FC_RUN: begin
          if (!iStall) begin
            if (iHalt) begin
              rd_en     <= 1'b0;
              drain_cnt <= '0;
              state     <= PE_FC_DRAIN;
            end else if (iBranch_Valid) begin
              pc <= iBranch_Target;
            end else if (loop_take) begin
              pc <= loop_start_pc;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        PE_FC_DRAIN: begin
          if (!iStall) begin
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt <= '0;
              done      <= 1'b1;
              state     <= PE_FC_IDLE;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
        end
        default: state <= PE_FC_IDLE;
      endcase
    end
  end

  assign oBusy         = (state != PE_FC_IDLE);
  assign oDone         = done;
  assign oIMEM_Addr    = pc;
  assign oIMEM_Read_En = rd_en;
  assign oFetch_Valid  = fetch_valid;

endmodule

// File: tb/tb_pe_fetch_ctrl.sv
// Directed bench for pe_fetch_ctrl: sequencing, branch,
// loop, stall, halt/drain, wrap and async reset.
module tb_pe_fetch_ctrl;

  localparam int PC_W = 10;
  localparam int LCW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            busy;
  logic            done;
  logic            stall;
  logic            br;
  logic [PC_W-1:0] br_tgt;
  logic            halt;
  logic            lset;
  logic [PC_W-1:0] lstart;
  logic [PC_W-1:0] lend;
  logic [LCW-1:0]  lcnt;
  logic [PC_W-1:0] addr;
  logic            ren;
  logic            fv;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pe_fetch_ctrl #(
    .PC_W         (PC_W),
    .LOOP_CNT_W   (LCW),
    .DRAIN_CYCLES (3)
  ) dut (
    .iClk           (clk),
    .iReset_n       (rst_n),
    .iStart         (start),
    .iStart_PC      (start_pc),
    .oBusy          (busy),
    .oDone          (done),
    .iStall         (stall),
    .iBranch_Valid  (br),
    .iBranch_Target (br_tgt),
    .iHalt          (halt),
    .iLoop_Set      (lset),
    .iLoop_Start    (lstart),
    .iLoop_End      (lend),
    .iLoop_Count    (lcnt),
    .oIMEM_Addr     (addr),
    .oIMEM_Read_En  (ren),
    .oFetch_Valid   (fv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {addr, ren, fv, busy, done}
  function automatic logic [PC_W+3:0] snap();
    return {addr, ren, fv, busy, done};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 0; start_pc = '0;
    stall = 0; br = 0; br_tgt = '0; halt = 0;
    lset = 0; lstart = '0; lend = '0; lcnt = '0;
    tick(); tick();
    checks++;
    if (snap() !== '0)
      $display("FAIL reset_outs: got %h want %h",
               snap(), 14'h0);
    else passed++;
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== '0)
      $display("FAIL idle_outs: got %h want %h",
               snap(), 14'h0);
    else passed++;
  endtask

  task automatic test_sequential();
    start = 1; start_pc = 10'h010;
    tick();
    start = 0;
    checks++;
    if ({addr, ren, fv, busy} !== {10'h010, 3'b101})
      $display("FAIL start_first: got %h/%b%b%b want 010/101",
               addr, ren, fv, busy);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({addr, fv} !== {10'h010 + 10'(i), 1'b1})
        $display("FAIL seq_%0d: got %h/%b want %h/1",
                 i, addr, fv, 10'h010 + 10'(i));
      else passed++;
    end
  endtask

  task automatic test_branch();
    br = 1; br_tgt = 10'h200;
    tick();
    br = 0;
    checks++;
    if ({addr, fv, ren} !== {10'h200, 2'b01})
      $display("FAIL br_squash: got %h/%b%b want 200/01",
               addr, fv, ren);
    else passed++;
    tick();
    checks++;
    if ({addr, fv} !== {10'h201, 1'b1})
      $display("FAIL br_target_valid: got %h/%b want 201/1",
               addr, fv);
    else passed++;
    tick();
    checks++;
    if ({addr, fv} !== {10'h202, 1'b1})
      $display("FAIL br_no_bubble: got %h/%b want 202/1",
               addr, fv);
    else passed++;
  endtask

  task automatic test_loop();
    logic [PC_W-1:0] exp_seq [12];
    exp_seq = '{10'h01F, 10'h020, 10'h021, 10'h022,
                10'h020, 10'h021, 10'h022, 10'h020,
                10'h021, 10'h022, 10'h023, 10'h024};
    br = 1; br_tgt = 10'h01E;
    lset = 1; lstart = 10'h020; lend = 10'h022;
    lcnt = 8'd3;
    tick();
    br = 0; lset = 0;
    checks++;
    if ({addr, fv} !== {10'h01E, 1'b0})
      $display("FAIL loop_entry: got %h/%b want 01e/0",
               addr, fv);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({addr, fv} !== {exp_seq[i], 1'b1})
        $display("FAIL loop_seq_%0d: got %h/%b want %h/1",
                 i, addr, fv, exp_seq[i]);
      else passed++;
    end
    // Re-enter the old body; it must not loop again.
    br = 1; br_tgt = 10'h021;
    tick();
    br = 0;
    tick();
    tick();
    checks++;
    if ({addr, fv} !== {10'h023, 1'b1})
      $display("FAIL loop_disarmed: got %h/%b want 023/1",
               addr, fv);
    else passed++;
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] exp_seq [5];
    exp_seq = '{10'h022, 10'h020, 10'h021,
                10'h022, 10'h023};
    br = 1; br_tgt = 10'h020;
    lset = 1; lstart = 10'h020; lend = 10'h022;
    lcnt = 8'd2;
    tick();
    br = 0; lset = 0;
    tick();
    checks++;
    if ({addr, fv} !== {10'h021, 1'b1})
      $display("FAIL stall_pre: got %h/%b want 021/1",
               addr, fv);
    else passed++;
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap() !== {10'h021, 4'b1110})
        $display("FAIL loop_stall_%0d: got %h want %h",
                 i, snap(), {10'h021, 4'b1110});
      else passed++;
    end
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({addr, fv} !== {exp_seq[i], 1'b1})
        $display("FAIL stall_seq_%0d: got %h/%b want %h/1",
                 i, addr, fv, exp_seq[i]);
      else passed++;
    end
    br = 1; br_tgt = 10'h100; stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap() !== {10'h023, 4'b1110})
        $display("FAIL br_stall_%0d: got %h want %h",
                 i, snap(), {10'h023, 4'b1110});
      else passed++;
    end
    stall = 0;
    tick();
    br = 0;
    checks++;
    if ({addr, fv} !== {10'h100, 1'b0})
      $display("FAIL br_after_stall: got %h/%b want 100/0",
               addr, fv);
    else passed++;
    tick();
    checks++;
    if ({addr, fv} !== {10'h101, 1'b1})
      $display("FAIL br_after_stall_next: got %h/%b want 101/1",
               addr, fv);
    else passed++;
  endtask

  task automatic test_halt();
    br = 1; br_tgt = 10'h02F;
    tick();
    br = 0;
    tick();
    checks++;
    if ({addr, fv} !== {10'h030, 1'b1})
      $display("FAIL halt_pre: got %h/%b want 030/1",
               addr, fv);
    else passed++;
    halt = 1;
    tick();
    halt = 0;
    start = 1; start_pc = 10'h055;
    checks++;
    if (snap() !== {10'h030, 4'b0010})
      $display("FAIL halt_accept: got %h want %h",
               snap(), {10'h030, 4'b0010});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap() !== {10'h030, 4'b0010})
        $display("FAIL drain_%0d: got %h want %h",
                 i, snap(), {10'h030, 4'b0010});
      else passed++;
    end
    start = 0;
    tick();
    checks++;
    if (snap() !== {10'h030, 4'b0001})
      $display("FAIL done_pulse: got %h want %h",
               snap(), {10'h030, 4'b0001});
    else passed++;
    tick();
    checks++;
    if (snap() !== {10'h030, 4'b0000})
      $display("FAIL idle_after_done: got %h want %h",
               snap(), {10'h030, 4'b0000});
    else passed++;
  endtask

  task automatic test_wrap_reset();
    start = 1; start_pc = 10'h3FF;
    tick();
    start = 0;
    checks++;
    if ({addr, ren} !== {10'h3FF, 1'b1})
      $display("FAIL wrap_start: got %h/%b want 3ff/1",
               addr, ren);
    else passed++;
    tick();
    checks++;
    if ({addr, fv} !== {10'h000, 1'b1})
      $display("FAIL wrap: got %h/%b want 000/1",
               addr, fv);
    else passed++;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== '0)
      $display("FAIL async_reset: got %h want %h",
               snap(), 14'h0);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== '0)
      $display("FAIL post_reset_idle: got %h want %h",
               snap(), 14'h0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_loop();
    test_stall();
    test_halt();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
